alu_exec_unit: RTL and testbench

Parametrised execute stage for the mini-processor datapath.
- Single-cycle logic/arithmetic/shift operations with registered results and flags.
- Iterative shift-add multiplier producing a full 2*WIDTH product, in unsigned and signed modes.
- valid/ready handshake, so the decode stage stalls while a multiply is in flight.
- Successor to the fixed 16/32-bit combinational ALU; removes the combinational multiplier from the critical path.

---
 rtl/alu_exec_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arithmetic/shift ops and an iterative shift-add multiplier.
// Define SIGNED_MUL_EN to build signed multiply (SMUL); otherwise opcode 9 is illegal.
module alu_exec_unit #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEST_WIDTH = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iValid,
   output logic                  oReady,
   input  logic [3:0]            iOperation,
   input  logic [WIDTH-1:0]      iA,
   input  logic [WIDTH-1:0]      iB,
   input  logic [DEST_WIDTH-1:0] iDestination,
   output logic                  oValid,
   output logic [WIDTH-1:0]      oResult,
   output logic [WIDTH-1:0]      oResultHi,
   output logic [DEST_WIDTH-1:0] oDestination,
   output logic                  oZero,
   output logic                  oCarry,
   output logic                  oNegative,
   output logic                  oIllegal
);

   localparam int unsigned ShW = $clog2(WIDTH);

   localparam logic [3:0] OpNop  = 4'd0;
   localparam logic [3:0] OpAdd  = 4'd1;
   localparam logic [3:0] OpSub  = 4'd2;
   localparam logic [3:0] OpAnd  = 4'd3;
   localparam logic [3:0] OpOr   = 4'd4;
   localparam logic [3:0] OpXor  = 4'd5;
   localparam logic [3:0] OpShl  = 4'd6;
   localparam logic [3:0] OpShr  = 4'd7;
   localparam logic [3:0] OpMul  = 4'd8;
`ifdef SIGNED_MUL_EN
   localparam logic [3:0] OpSmul = 4'd9;
`endif

   typedef enum logic [1:0] {StIdle, StMulRun, StMulDone} stateT;

   stateT                 stateQ, stateD;
   logic [ShW-1:0]        countQ, countD;
   logic [WIDTH-1:0]      mcandQ, mcandD;
   logic [2*WIDTH-1:0]    prodQ, prodD;
   logic [DEST_WIDTH-1:0] destQ, destD;
`ifdef SIGNED_MUL_EN
   logic                  negateQ, negateD;
   logic                  signedQ, signedD;
`endif

   logic                  validQ, validD;
   logic [WIDTH-1:0]      resultQ, resultD;
   logic [WIDTH-1:0]      resultHiQ, resultHiD;
   logic [DEST_WIDTH-1:0] destOutQ, destOutD;
   logic                  zeroQ, zeroD;
   logic                  carryQ, carryD;
   logic                  negQ, negD;
   logic                  illegalQ, illegalD;

   // Single-cycle datapath
   logic [ShW-1:0]     shAmt;
   logic [WIDTH:0]     sum, diff, shl, shr;
   logic [WIDTH-1:0]   aluResult;
   logic               aluCarry;
   logic               aluLegal;

   always_comb begin
      shAmt     = iB[ShW-1:0];
      sum       = {1'b0, iA} + {1'b0, iB};
      diff      = {1'b0, iA} - {1'b0, iB};
      shl       = {1'b0, iA} << shAmt;
      shr       = {iA, 1'b0} >> shAmt;
      aluResult = '0;
      aluCarry  = 1'b0;
      aluLegal  = 1'b1;
      case (iOperation)
         OpAdd:   {aluCarry, aluResult} = sum;
         OpSub:   {aluCarry, aluResult} = diff;
         OpAnd:   aluResult = iA & iB;
         OpOr:    aluResult = iA | iB;
         OpXor:   aluResult = iA ^ iB;
         OpShl:   {aluCarry, aluResult} = shl;
         OpShr:   {aluResult, aluCarry} = shr;
         default: aluLegal = 1'b0;
      endcase
   end

   // Operand magnitudes and final product sign correction
   logic [WIDTH-1:0]   aMag, bMag;
   logic [2*WIDTH-1:0] finalProd;
   logic               mulOverflow;

   always_comb begin
`ifdef SIGNED_MUL_EN
      aMag = (iOperation == OpSmul && iA[WIDTH-1]) ? -iA : iA;
      bMag = (iOperation == OpSmul && iB[WIDTH-1]) ? -iB : iB;
      finalProd = negateQ ? -prodQ : prodQ;
      mulOverflow = signedQ
         ? (finalProd[2*WIDTH-1:WIDTH] != {WIDTH{finalProd[WIDTH-1]}})
         : (|finalProd[2*WIDTH-1:WIDTH]);
`else
      aMag = iA;
      bMag = iB;
      finalProd = prodQ;
      mulOverflow = |finalProd[2*WIDTH-1:WIDTH];
`endif
   end

   // One radix-2 step: conditionally add multiplicand to the high half, then shift right
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     partial;
   logic [2*WIDTH-1:0] stepProd;

   always_comb begin
      addend   = prodQ[0] ? mcandQ : '0;
      partial  = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      stepProd = {partial, prodQ[WIDTH-1:1]};
   end

   always_comb begin
      stateD    = stateQ;
      countD    = countQ;
      mcandD    = mcandQ;
      prodD     = prodQ;
      destD     = destQ;
`ifdef SIGNED_MUL_EN
      negateD   = negateQ;
      signedD   = signedQ;
`endif
      validD    = 1'b0;
      resultD   = resultQ;
      resultHiD = resultHiQ;
      destOutD  = destOutQ;
      zeroD     = zeroQ;
      carryD    = carryQ;
      negD      = negQ;
      illegalD  = illegalQ;

      unique case (stateQ)
         StIdle: begin
            if (iValid) begin
               case (iOperation)
                  OpNop: validD = 1'b0;
`ifdef SIGNED_MUL_EN
                  OpMul, OpSmul: begin
                     negateD = (iOperation == OpSmul) && (iA[WIDTH-1] ^ iB[WIDTH-1]);
                     signedD = (iOperation == OpSmul);
`else
                  OpMul: begin
`endif
                     stateD = StMulRun;
                     countD = '0;
                     mcandD = aMag;
                     prodD  = {{WIDTH{1'b0}}, bMag};
                     destD  = iDestination;
                  end
                  default: begin
                     validD    = 1'b1;
                     resultD   = aluResult;
                     resultHiD = '0;
                     destOutD  = iDestination;
                     zeroD     = aluLegal && (aluResult == '0);
                     carryD    = aluCarry;
                     negD      = aluResult[WIDTH-1];
                     illegalD  = !aluLegal;
                  end
               endcase
            end
         end
         StMulRun: begin
            prodD  = stepProd;
            countD = countQ + ShW'(1);
            if (countQ == ShW'(WIDTH - 1)) stateD = StMulDone;
         end
         StMulDone: begin
            stateD    = StIdle;
            validD    = 1'b1;
            resultD   = finalProd[WIDTH-1:0];
            resultHiD = finalProd[2*WIDTH-1:WIDTH];
            destOutD  = destQ;
            zeroD     = (finalProd == '0);
            carryD    = mulOverflow;
            negD      = finalProd[2*WIDTH-1];
            illegalD  = 1'b0;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         stateQ    <= StIdle;
         countQ    <= '0;
         mcandQ    <= '0;
         prodQ     <= '0;
         destQ     <= '0;
`ifdef SIGNED_MUL_EN
         negateQ   <= 1'b0;
         signedQ   <= 1'b0;
`endif
         validQ    <= 1'b0;
         resultQ   <= '0;
         resultHiQ <= '0;
         destOutQ  <= '0;
         zeroQ     <= 1'b0;
         carryQ    <= 1'b0;
         negQ      <= 1'b0;
         illegalQ  <= 1'b0;
      end else begin
         stateQ    <= stateD;
         countQ    <= countD;
         mcandQ    <= mcandD;
         prodQ     <= prodD;
         destQ     <= destD;
`ifdef SIGNED_MUL_EN
         negateQ   <= negateD;
         signedQ   <= signedD;
`endif
         validQ    <= validD;
         resultQ   <= resultD;
         resultHiQ <= resultHiD;
         destOutQ  <= destOutD;
         zeroQ     <= zeroD;
         carryQ    <= carryD;
         negQ      <= negD;
         illegalQ  <= illegalD;
      end
   end

   assign oReady       = (stateQ == StIdle);
   assign oValid       = validQ;
   assign oResult      = resultQ;
   assign oResultHi    = resultHiQ;
   assign oDestination = destOutQ;
   assign oZero        = zeroQ;
   assign oCarry       = carryQ;
   assign oNegative    = negQ;
   assign oIllegal     = illegalQ;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH = 16, DEST_WIDTH = 8).
module tb_alu_exec_unit;

   logic        Clock;
   logic        Reset;
   logic        iValid;
   logic        oReady;
   logic [3:0]  iOperation;
   logic [15:0] iA;
   logic [15:0] iB;
   logic [7:0]  iDestination;
   logic        oValid;
   logic [15:0] oResult;
   logic [15:0] oResultHi;
   logic [7:0]  oDestination;
   logic        oZero;
   logic        oCarry;
   logic        oNegative;
   logic        oIllegal;

   int checks = 0;
   int failures = 0;

   alu_exec_unit #(
      .WIDTH      (16),
      .DEST_WIDTH (8)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .iValid       (iValid),
      .oReady       (oReady),
      .iOperation   (iOperation),
      .iA           (iA),
      .iB           (iB),
      .iDestination (iDestination),
      .oValid       (oValid),
      .oResult      (oResult),
      .oResultHi    (oResultHi),
      .oDestination (oDestination),
      .oZero        (oZero),
      .oCarry       (oCarry),
      .oNegative    (oNegative),
      .oIllegal     (oIllegal)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] d);
      iValid = v;
      iOperation = op;
      iA = a;
      iB = b;
      iDestination = d;
   endtask

   // Bundle: {oReady, oValid, oIllegal, oZero, oCarry, oNegative, oDestination, oResultHi, oResult}
   task automatic test_reset();
      logic [45:0] got;
      Reset = 1'b1;
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
      tick();
      tick();
      Reset = 1'b0;
      got = {oReady, oValid, oIllegal, oZero, oCarry, oNegative, oDestination, oResultHi, oResult};
      checks++;
      if (got !== {1'b1, 45'd0}) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", got, {1'b1, 45'd0});
      end
   endtask

   task automatic test_add();
      drive(1'b1, 4'd1, 16'hFFFF, 16'h0001, 8'h05);
      tick();
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
      checks++;
      if ({oValid, oResult, oResultHi, oCarry, oZero, oNegative, oIllegal, oDestination} !==
          {1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05}) begin
         failures++;
         $display("FAIL add_carry: got v=%b r=%h hi=%h c=%b z=%b n=%b ill=%b d=%h expected v=1 r=0000 hi=0000 c=1 z=1 n=0 ill=0 d=05",
                  oValid, oResult, oResultHi, oCarry, oZero, oNegative, oIllegal, oDestination);
      end
      tick();
      checks++;
      if ({oValid, oResult, oCarry, oDestination} !== {1'b0, 16'h0000, 1'b1, 8'h05}) begin
         failures++;
         $display("FAIL add_hold: got v=%b r=%h c=%b d=%h expected v=0 r=0000 c=1 d=05",
                  oValid, oResult, oCarry, oDestination);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 4'd2, 16'h0003, 16'h0005, 8'h11);
      tick();
      drive(1'b1, 4'd6, 16'h8001, 16'h0001, 8'h12);
      checks++;
      if ({oValid, oResult, oCarry, oZero, oNegative, oDestination} !==
          {1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1, 8'h11}) begin
         failures++;
         $display("FAIL sub_borrow: got v=%b r=%h c=%b z=%b n=%b d=%h expected v=1 r=fffe c=1 z=0 n=1 d=11",
                  oValid, oResult, oCarry, oZero, oNegative, oDestination);
      end
      tick();
      drive(1'b1, 4'd7, 16'h0003, 16'h0000, 8'h13);
      checks++;
      if ({oValid, oResult, oCarry, oNegative, oDestination} !==
          {1'b1, 16'h0002, 1'b1, 1'b0, 8'h12}) begin
         failures++;
         $display("FAIL shl_b2b: got v=%b r=%h c=%b n=%b d=%h expected v=1 r=0002 c=1 n=0 d=12",
                  oValid, oResult, oCarry, oNegative, oDestination);
      end
      tick();
      drive(1'b1, 4'd5, 16'hF0F0, 16'hFF00, 8'h14);
      checks++;
      if ({oValid, oResult, oCarry} !== {1'b1, 16'h0003, 1'b0}) begin
         failures++;
         $display("FAIL shr_amount0: got v=%b r=%h c=%b expected v=1 r=0003 c=0",
                  oValid, oResult, oCarry);
      end
      tick();
      drive(1'b1, 4'd7, 16'h00F3, 16'h0013, 8'h15);
      checks++;
      if ({oValid, oResult, oCarry, oNegative} !== {1'b1, 16'h0FF0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL xor: got v=%b r=%h c=%b n=%b expected v=1 r=0ff0 c=0 n=0",
                  oValid, oResult, oCarry, oNegative);
      end
      tick();
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
      // SHR by 3 (amount from low 4 bits of 0x13): 0xF3 >> 3 = 0x1E, last bit out = bit 2 = 0
      checks++;
      if ({oValid, oResult, oCarry} !== {1'b1, 16'h001E, 1'b0}) begin
         failures++;
         $display("FAIL shr_3: got v=%b r=%h c=%b expected v=1 r=001e c=0",
                  oValid, oResult, oCarry);
      end
      tick();
      checks++;
      if (oValid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: got v=%b expected v=0", oValid);
      end
   endtask

   task automatic test_mul();
      int badBusy = 0;
      drive(1'b1, 4'd8, 16'hFFFF, 16'hFFFF, 8'h07);
      tick();
      // Offer an ADD throughout the run; it must never be taken.
      drive(1'b1, 4'd1, 16'h0001, 16'h0001, 8'h09);
      for (int i = 0; i < 17; i++) begin
         if (oReady !== 1'b0 || oValid !== 1'b0) badBusy++;
         if (i == 16) drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
         tick();
      end
      checks++;
      if (badBusy != 0) begin
         failures++;
         $display("FAIL mul_busy: got %0d cycles with ready/valid set expected 0", badBusy);
      end
      checks++;
      if ({oValid, oReady, oResultHi, oResult, oCarry, oZero, oNegative, oIllegal, oDestination} !==
          {1'b1, 1'b1, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07}) begin
         failures++;
         $display("FAIL mul_result: got v=%b rdy=%b p=%h_%h c=%b z=%b n=%b ill=%b d=%h expected v=1 rdy=1 p=fffe_0001 c=1 z=0 n=1 ill=0 d=07",
                  oValid, oReady, oResultHi, oResult, oCarry, oZero, oNegative, oIllegal,
                  oDestination);
      end
      tick();
      checks++;
      if ({oValid, oResult, oDestination} !== {1'b0, 16'h0001, 8'h07}) begin
         failures++;
         $display("FAIL mul_no_extra: got v=%b r=%h d=%h expected v=0 r=0001 d=07",
                  oValid, oResult, oDestination);
      end
   endtask

   task automatic test_smul();
      drive(1'b1, 4'd9, 16'hFFFD, 16'h0005, 8'h21);
      tick();
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
`ifdef SIGNED_MUL_EN
      for (int i = 0; i < 17; i++) tick();
      checks++;
      if ({oValid, oResultHi, oResult, oCarry, oZero, oNegative, oIllegal, oDestination} !==
          {1'b1, 16'hFFFF, 16'hFFF1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h21}) begin
         failures++;
         $display("FAIL smul_result: got v=%b p=%h_%h c=%b z=%b n=%b ill=%b d=%h expected v=1 p=ffff_fff1 c=0 z=0 n=1 ill=0 d=21",
                  oValid, oResultHi, oResult, oCarry, oZero, oNegative, oIllegal, oDestination);
      end
`else
      checks++;
      if ({oValid, oIllegal, oReady, oResult, oResultHi, oCarry, oZero, oNegative, oDestination} !==
          {1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h21}) begin
         failures++;
         $display("FAIL smul_illegal: got v=%b ill=%b rdy=%b r=%h hi=%h c=%b z=%b n=%b d=%h expected v=1 ill=1 rdy=1 r=0000 hi=0000 c=0 z=0 n=0 d=21",
                  oValid, oIllegal, oReady, oResult, oResultHi, oCarry, oZero, oNegative,
                  oDestination);
      end
`endif
      tick();
   endtask

   task automatic test_illegal();
      drive(1'b1, 4'd3, 16'hFF0F, 16'h0FFF, 8'h30);
      tick();
      drive(1'b1, 4'd12, 16'h1234, 16'h5678, 8'h31);
      checks++;
      if ({oValid, oResult, oIllegal} !== {1'b1, 16'h0F0F, 1'b0}) begin
         failures++;
         $display("FAIL and: got v=%b r=%h ill=%b expected v=1 r=0f0f ill=0", oValid, oResult,
                  oIllegal);
      end
      tick();
      drive(1'b1, 4'd0, 16'hAAAA, 16'h5555, 8'h32);
      checks++;
      if ({oValid, oIllegal, oResult, oZero, oCarry, oDestination} !==
          {1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h31}) begin
         failures++;
         $display("FAIL op12_illegal: got v=%b ill=%b r=%h z=%b c=%b d=%h expected v=1 ill=1 r=0000 z=0 c=0 d=31",
                  oValid, oIllegal, oResult, oZero, oCarry, oDestination);
      end
      tick();
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
      checks++;
      if ({oValid, oIllegal, oDestination} !== {1'b0, 1'b1, 8'h31}) begin
         failures++;
         $display("FAIL nop_silent: got v=%b ill=%b d=%h expected v=0 ill=1 d=31", oValid,
                  oIllegal, oDestination);
      end
   endtask

   task automatic test_mul_abort();
      int spurious = 0;
      drive(1'b1, 4'd8, 16'h1234, 16'h0002, 8'h40);
      tick();
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
      for (int i = 0; i < 4; i++) tick();
      // Reset coincides with an offered ADD; reset must win.
      Reset = 1'b1;
      drive(1'b1, 4'd1, 16'h0001, 16'h0001, 8'h33);
      tick();
      Reset = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
      checks++;
      if ({oReady, oValid, oIllegal, oZero, oCarry, oNegative, oDestination, oResultHi, oResult} !==
          {1'b1, 45'd0}) begin
         failures++;
         $display("FAIL abort_state: got rdy=%b v=%b ill=%b z=%b c=%b n=%b d=%h p=%h_%h expected rdy=1 others 0",
                  oReady, oValid, oIllegal, oZero, oCarry, oNegative, oDestination, oResultHi,
                  oResult);
      end
      for (int i = 0; i < 24; i++) begin
         if (oValid !== 1'b0) spurious++;
         tick();
      end
      checks++;
      if (spurious != 0) begin
         failures++;
         $display("FAIL abort_no_valid: got %0d oValid cycles expected 0", spurious);
      end
      drive(1'b1, 4'd1, 16'h0001, 16'h0001, 8'h41);
      tick();
      drive(1'b0, 4'd0, 16'h0, 16'h0, 8'h0);
      checks++;
      if ({oValid, oResult, oResultHi, oCarry, oZero, oDestination} !==
          {1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0, 8'h41}) begin
         failures++;
         $display("FAIL add_after_abort: got v=%b r=%h hi=%h c=%b z=%b d=%h expected v=1 r=0002 hi=0000 c=0 z=0 d=41",
                  oValid, oResult, oResultHi, oCarry, oZero, oDestination);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_mul();
      test_smul();
      test_illegal();
      test_mul_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
